// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, the bubble
// instruction and the fetch FSM state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_SW    = 6'b110101;
  localparam logic [5:0] OP_BEQ   = 6'b001000;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    FETCH     = 2'd1,
    KILL      = 2'd2,
    WAIT_SLOT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request bus: the fetch stage is master, memory is slave.
// imem_ready acknowledges the request and qualifies imem_rdata in the same cycle.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_if_id_slot.sv
// IF/ID slot: the register seen by decode plus a one-entry skid buffer that
// catches the word returning while decode is stalled. A flush (redirect)
// empties both; a bubble always presents the NOP encoding.
module if_id_slot
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   capture,
  input  logic [INSTR_WIDTH-1:0] cap_instr,
  input  logic [ADDR_WIDTH-1:0]  cap_pc_plus4,
  output logic                   slot_free,
  output logic                   buf_full,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [5:0]             op_code,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus4
);

  logic [INSTR_WIDTH-1:0] slot_instr;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic [ADDR_WIDTH-1:0]  buf_pc_plus4;
  logic                   load_from_fetch;
  logic                   load_from_buf;
  logic                   load_buf;

  // Decode consumes the slot on any cycle it is not stalling.
  assign slot_free = !if_valid || !stall;

  // Decide where a word moves this cycle; a flush suppresses every move.
  always_comb begin
    load_from_fetch = 1'b0;
    load_from_buf   = 1'b0;
    load_buf        = 1'b0;
    if (!flush) begin
      if (buf_full) begin
        load_from_buf = !stall;
      end else if (capture) begin
        if (slot_free) load_from_fetch = 1'b1;
        else           load_buf        = 1'b1;
      end
    end
  end

  // Slot/buffer occupancy; a consumed slot with nothing behind it becomes a bubble.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      buf_full <= 1'b0;
    end else if (flush) begin
      if_valid <= 1'b0;
      buf_full <= 1'b0;
    end else begin
      if (load_from_fetch || load_from_buf) if_valid <= 1'b1;
      else if (!stall)                      if_valid <= 1'b0;
      if (load_buf)           buf_full <= 1'b1;
      else if (load_from_buf) buf_full <= 1'b0;
    end
  end

  // Slot contents; held bit-stable whenever nothing is loaded.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_instr  <= INSTR_WIDTH'(INSTR_NOP);
      if_pc_plus4 <= '0;
    end else if (load_from_fetch) begin
      slot_instr  <= cap_instr;
      if_pc_plus4 <= cap_pc_plus4;
    end else if (load_from_buf) begin
      slot_instr  <= buf_instr;
      if_pc_plus4 <= buf_pc_plus4;
    end
  end

  // Skid buffer payload; only meaningful while buf_full is set.
  always_ff @(posedge clock) begin
    if (load_buf) begin
      buf_instr    <= cap_instr;
      buf_pc_plus4 <= cap_pc_plus4;
    end
  end

  // Bubbles read as NOP so downstream sees opcode 0 with if_valid low.
  assign if_instr = if_valid ? slot_instr : INSTR_WIDTH'(INSTR_NOP);
  assign op_code  = if_instr[31:26];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC and the fetch FSM, issues requests on
// the imem bus and hands returned words to the IF/ID slot. A redirect while a
// request is still waiting keeps the stale address on the bus (KILL) until
// memory accepts it, then drops that word.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  instruction_fetch_if.master    imem,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [5:0]             op_code,
  output logic [ADDR_WIDTH-1:0]  if_pc_plus4
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  fetch_state_t          state;
  fetch_state_t          next_state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] kill_addr;
  logic [ADDR_WIDTH-1:0] kill_addr_next;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target;
  logic                  slot_free;
  logic                  buf_full;
  logic                  flush;
  logic                  capture;

  assign pc_plus4 = pc + PC_STEP;
  assign target   = branch_target & ALIGN_MASK;

  assign imem.imem_req  = (state == FETCH) || (state == KILL);
  assign imem.imem_addr = (state == KILL) ? kill_addr : pc;

  assign flush   = branch_taken && (state != BOOT);
  assign capture = (state == FETCH) && imem.imem_ready && !branch_taken;

  // FSM state, PC and the address of a request being killed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      kill_addr <= RESET_PC;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      kill_addr <= kill_addr_next;
    end
  end

  // Next-state and PC selection; a redirect outranks stall everywhere.
  always_comb begin
    next_state     = state;
    pc_next        = pc;
    kill_addr_next = kill_addr;
    case (state)
      BOOT: begin
        next_state = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          pc_next = target;
          if (!imem.imem_ready) begin
            next_state     = KILL;
            kill_addr_next = pc;
          end
        end else if (imem.imem_ready) begin
          pc_next = pc_plus4;
          if (!slot_free) next_state = WAIT_SLOT;
        end
      end
      KILL: begin
        if (branch_taken)     pc_next    = target;
        if (imem.imem_ready)  next_state = FETCH;
      end
      WAIT_SLOT: begin
        if (branch_taken) begin
          pc_next    = target;
          next_state = FETCH;
        end else if (!stall) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  if_id_slot #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_slot (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .flush        (flush),
    .capture      (capture),
    .cap_instr    (imem.imem_rdata),
    .cap_pc_plus4 (pc_plus4),
    .slot_free    (slot_free),
    .buf_full     (buf_full),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .op_code      (op_code),
    .if_pc_plus4  (if_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed stimulus with literal expectations,
// plus a transaction-level model (queue-based skid buffer) compared every cycle.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  op_code;
  logic [31:0] if_pc_plus4;

  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [31:0] w_pc4;
  logic        w_stall;
  logic        w_branch;
  logic [31:0] w_target;

  int checks = 0;
  int passed = 0;

  instruction_fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem_bus ();
  instruction_fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) wrap_bus ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem = 32'hC422_0004;
      32'h0000_0004: mem = 32'hD441_0008;
      32'h0000_0008: mem = 32'h2022_0003;
      default:       mem = {6'b000010, a[27:2]};
    endcase
  endfunction

  assign imem_bus.imem_ready = ready;
  assign imem_bus.imem_rdata = mem(imem_bus.imem_addr);
  assign wrap_bus.imem_ready = 1'b1;
  assign wrap_bus.imem_rdata = mem(wrap_bus.imem_addr);

  instruction_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem          (imem_bus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .op_code       (op_code),
    .if_pc_plus4   (if_pc_plus4)
  );

  assign w_stall  = 1'b0;
  assign w_branch = 1'b0;
  assign w_target = 32'h0;

  instruction_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem          (wrap_bus),
    .stall         (w_stall),
    .branch_taken  (w_branch),
    .branch_target (w_target),
    .if_valid      (w_valid),
    .if_instr      (w_instr),
    .op_code       (w_op),
    .if_pc_plus4   (w_pc4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        skid[$];
  bit          known = 0;
  bit          booting;
  bit          stale;
  logic [31:0] stale_addr;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  // Advance the model by one clock using the inputs the next edge will sample.
  task automatic model_step();
    ent_t        e;
    logic [31:0] word;
    logic [31:0] tgt;
    tgt = branch_target & 32'hFFFF_FFFC;
    if (!reset_n) begin
      known = 1; booting = 1; stale = 0; stale_addr = 0;
      m_pc = 0; m_valid = 0; m_instr = 0; m_pc4 = 0;
      skid.delete();
    end else if (!known) begin
      known = 0;
    end else if (booting) begin
      booting = 0;
    end else if (skid.size() != 0) begin
      if (branch_taken) begin
        skid.delete(); m_valid = 0; m_pc = tgt;
      end else if (!stall) begin
        e = skid.pop_front();
        m_instr = e.instr; m_pc4 = e.pc4; m_valid = 1;
      end
    end else if (stale) begin
      if (branch_taken) m_pc = tgt;
      if (ready) stale = 0;
    end else begin
      word = mem(m_pc);
      if (branch_taken) begin
        m_valid = 0;
        if (!ready) begin stale = 1; stale_addr = m_pc; end
        m_pc = tgt;
      end else if (ready) begin
        if (!m_valid || !stall) begin
          m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1;
        end else begin
          skid.push_back({word, m_pc + 32'd4});
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_valid = 0;
      end
    end
  endtask

  // Compare on the falling edge, then step the model.
  initial begin
    logic        exp_req;
    logic [31:0] exp_instr;
    forever begin
      @(negedge clock);
      if (known) begin
        exp_req   = !booting && (skid.size() == 0);
        exp_instr = m_valid ? m_instr : 32'h0;
        check("model_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
        if (exp_req || booting)
          check("model_addr", imem_bus.imem_addr, stale ? stale_addr : m_pc);
        check("model_valid", {31'b0, if_valid}, {31'b0, m_valid});
        check("model_instr", if_instr, exp_instr);
        check("model_opcode", {26'b0, op_code}, {26'b0, exp_instr[31:26]});
        if (m_valid || booting)
          check("model_pc4", if_pc_plus4, m_pc4);
      end
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  logic [23:0] rdy_pat;
  logic [23:0] stl_pat;
  logic [23:0] br_pat;

  initial begin
    reset_n = 1'b0; ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    rdy_pat = 24'b1101_1110_0111_1011_1101_1111;
    stl_pat = 24'b0011_0000_1100_0110_0001_1000;
    br_pat  = 24'b0000_0100_0000_0010_0000_0100;
    repeat (3) tick();
    // cycle 0: reset state
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("rst_addr", imem_bus.imem_addr, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h0);
    check("wrap_rst_addr", wrap_bus.imem_addr, 32'hFFFF_FFFC);
    reset_n = 1'b1;
    tick(); // cycle 1
    check("boot_req", {31'b0, imem_bus.imem_req}, 32'h1);
    check("boot_addr", imem_bus.imem_addr, 32'h0);
    check("wrap_addr1", wrap_bus.imem_addr, 32'hFFFF_FFFC);
    tick(); // cycle 2
    check("boot_valid", {31'b0, if_valid}, 32'h1);
    check("boot_opcode", {26'b0, op_code}, {26'b0, OP_LW});
    check("boot_pc4", if_pc_plus4, 32'h4);
    check("stream_addr4", imem_bus.imem_addr, 32'h4);
    check("wrap_addr2", wrap_bus.imem_addr, 32'h0);
    check("wrap_pc4", w_pc4, 32'h0);
    tick(); // cycle 3
    check("stream_instr_sw", if_instr, 32'hD441_0008);
    check("stream_addr8", imem_bus.imem_addr, 32'h8);
    stall = 1'b1;
    tick(); // cycle 4
    check("stall_req0", {31'b0, imem_bus.imem_req}, 32'h0);
    tick(); // cycle 5
    tick(); // cycle 6
    check("stall_hold_instr", if_instr, 32'hD441_0008);
    check("stall_hold_op", {26'b0, op_code}, {26'b0, OP_SW});
    check("stall_hold_pc4", if_pc_plus4, 32'h8);
    tick(); // cycle 7
    check("stall_req0_last", {31'b0, imem_bus.imem_req}, 32'h0);
    stall = 1'b0;
    tick(); // cycle 8
    check("unstall_instr", if_instr, 32'h2022_0003);
    check("unstall_op", {26'b0, op_code}, {26'b0, OP_BEQ});
    check("unstall_pc4", if_pc_plus4, 32'hC);
    check("unstall_addr", imem_bus.imem_addr, 32'hC);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h23;
    tick(); // cycle 9
    check("flush_valid", {31'b0, if_valid}, 32'h0);
    check("flush_op", {26'b0, op_code}, {26'b0, OP_RTYPE});
    check("flush_addr", imem_bus.imem_addr, 32'h20);
    stall = 1'b0; branch_taken = 1'b0;
    tick(); // cycle 10
    check("target_instr", if_instr, 32'h0800_0008);
    check("target_pc4", if_pc_plus4, 32'h24);
    branch_taken = 1'b1; branch_target = 32'h10;
    tick(); // cycle 11
    check("redir_addr10", imem_bus.imem_addr, 32'h10);
    branch_taken = 1'b0; ready = 1'b0;
    tick(); // cycle 12
    check("wait_addr10", imem_bus.imem_addr, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); // cycle 13
    check("kill_addr_held", imem_bus.imem_addr, 32'h10);
    check("kill_req", {31'b0, imem_bus.imem_req}, 32'h1);
    branch_taken = 1'b0;
    tick(); // cycle 14
    check("kill_addr_held2", imem_bus.imem_addr, 32'h10);
    ready = 1'b1;
    tick(); // cycle 15
    check("kill_done_addr", imem_bus.imem_addr, 32'h40);
    check("kill_done_valid", {31'b0, if_valid}, 32'h0);
    tick(); // cycle 16
    check("kill_target_instr", if_instr, 32'h0800_0010);
    check("kill_target_pc4", if_pc_plus4, 32'h44);
    ready = 1'b0;
    tick(); // cycle 17
    check("midrst_pre_req", {31'b0, imem_bus.imem_req}, 32'h1);
    reset_n = 1'b0;
    tick(); // cycle 18
    check("midrst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("midrst_valid", {31'b0, if_valid}, 32'h0);
    check("midrst_addr", imem_bus.imem_addr, 32'h0);
    reset_n = 1'b1;
    tick(); // cycle 19
    check("reboot_req", {31'b0, imem_bus.imem_req}, 32'h1);
    ready = 1'b1;
    tick(); // cycle 20
    check("reboot_instr", if_instr, 32'hC422_0004);
    // mixed ready/stall/redirect traffic, checked by the model
    for (int i = 0; i < 24; i++) begin
      ready         = rdy_pat[i];
      stall         = stl_pat[i];
      branch_taken  = br_pat[i];
      branch_target = 32'h100 + 32'(i) * 32'd12 + 32'd1;
      tick();
    end
    ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the main control decoder.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ready handshake.
- Presents one IF/ID slot (instruction, opcode, PC+4, valid) to decode.
- Supports decode stall and branch redirect, with correct discard of in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, width of the PC and of the instruction-memory byte address.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, byte address of the first fetch after reset.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_WIDTH  byte address of the request.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  INSTR_WIDTH  instruction data, valid when imem_req && imem_ready.
- stall  in  1  decode cannot accept; the slot must hold.
- branch_taken  in  1  one-cycle redirect pulse from the branch resolve logic.
- branch_target  in  ADDR_WIDTH  redirect byte address.
- if_valid  out  1  slot holds a live instruction.
- if_instr  out  INSTR_WIDTH  instruction in the slot.
- op_code  out  6  if_instr[31:26], fed to the control decoder.
- if_pc_plus4  out  ADDR_WIDTH  fetch address + 4 of the slot instruction.

Behaviour:
- Reset (reset_n=0 sampled at an edge):
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, op_code=0, if_pc_plus4=0.
  - State: pc=RESET_PC, buffer empty, state BOOT.
  - Reset mid-fetch abandons the request; no data is captured.
- Bubble encoding: when if_valid=0, if_instr is forced to 0. Downstream gates regWrite and memWrite with if_valid, because opcode 000000 decodes as R-type.
- Handshake:
  - imem_addr must stay stable while imem_req=1, until a cycle with imem_ready=1.
  - imem_req never drops without a completed transfer, except on reset.
- PC arithmetic: pc+4 is modulo 2^ADDR_WIDTH; 0xFFFFFFFC wraps to 0x00000000. branch_target[1:0] are ignored and treated as 00.
- Slot free condition: slot_free = !if_valid || !stall.
- State BOOT: imem_req=0. Next state is FETCH. The first request is therefore issued in the cycle after reset release.
- State FETCH: imem_req=1, imem_addr=pc.
  - branch_taken=1: if_valid<=0 and pc<=target. If imem_ready=1, the word is discarded and the state stays FETCH; otherwise go to KILL.
  - imem_ready=1 and slot_free: slot<=rdata, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4; stay in FETCH. Back-to-back fetch gives 1 instruction per cycle.
  - imem_ready=1 and !slot_free: buffer<=rdata with its pc+4, pc<=pc+4; go to WAIT_SLOT.
- State KILL: imem_req=1, imem_addr=stale address held from before the redirect.
  - On imem_ready: discard the data and go to FETCH with the new pc.
  - A new branch_taken in KILL overwrites the pending target.
- State WAIT_SLOT: imem_req=0.
  - If !stall: the buffer moves into the slot, if_valid=1; go to FETCH.
  - branch_taken: drop the buffer, if_valid<=0, pc<=target; go to FETCH.
- Precedence: reset > branch_taken > stall. If redirect and stall coincide, the slot is flushed.
- Stall with if_valid=1: if_instr, op_code and if_pc_plus4 hold bit-stable.
- Latency: with imem_ready tied high, if_valid is first 1 two cycles after reset release.

Decomposition:
- Shared package (cpu_pkg), contents:
  - Opcode constants: OP_RTYPE=6'b000000, OP_LW=6'b110001, OP_SW=6'b110101, OP_BEQ=6'b001000.
  - INSTR_NOP=32'h0.
  - Fetch state encoding: BOOT, FETCH, KILL, WAIT_SLOT.
- One sub-module, if_id_slot: owns the output register, the one-entry skid buffer, and the stall/flush logic.
- The FSM and PC stay in instruction_fetch.

Test Plan:
- Boot: reset_n low 3 cycles then high, imem_ready=1, rdata=0xC4220004 (lw). Required: imem_addr=0x0 in cycle 1; if_valid=1, op_code=6'b110001, if_pc_plus4=0x4 in cycle 2.
- Streaming: ready=1, no stall. Required: addresses 0x0,0x4,0x8,0xC on consecutive cycles, and the slot updates every cycle.
- Stall with buffer: stall=1 for 4 cycles while slot holds sw 0xD4410008.
  - Slot stays stable and exactly one extra word is buffered.
  - imem_req=0 while the buffer is full.
  - On stall release, the buffered word appears next cycle; the next fetch address is correct.
- Redirect during outstanding request: imem_ready=0 at addr 0x10, branch_taken with target 0x40.
  - imem_addr stays 0x10 until ready; that data never reaches the slot.
  - Next request is 0x40; if_valid=0 in between.
- Redirect plus stall same cycle, with beq 0x20220003 in the slot: if_valid=0 next cycle, and fetch resumes at the target.
- PC wrap and mid-fetch reset:
  - RESET_PC=0xFFFFFFFC: second fetch address is 0x0.
  - Asserting reset_n=0 while imem_req=1 waiting drops imem_req and if_valid next edge.
